// File: rtl/psum_drain.sv
// Collects PE-array psums a fixed latency after start and streams them out lane by lane.
// Define PSUM_DRAIN_ACC_EN to sum PASSES captures per drain instead of draining every capture.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start
// S_WAIT    | counting down the array latency
// S_CAPTURE | lane register holds the new capture; choose drain or idle
// S_DRAIN   | presenting lanes on the valid/ready stream
module psum_drain #(
  parameter int PE_WIDTH  = 4,
  parameter int NUM_LANES = 3,
  parameter int LATENCY   = 30,
  parameter int PASSES    = 3
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 start,
  input  logic [PE_WIDTH*NUM_LANES-1:0]                        psum_in_flat,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  output logic [PE_WIDTH-1:0]                                  out_data,
  output logic [((NUM_LANES > 1) ? $clog2(NUM_LANES) : 1)-1:0] out_lane,
  output logic                                                 out_last,
  output logic                                                 busy,
  output logic                                                 overrun
);

  localparam int LANE_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
  localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int PASS_W = $clog2(PASSES + 1);
`ifdef PSUM_DRAIN_ACC_EN
  localparam int PASS_TARGET = PASSES;
`else
  localparam int PASS_TARGET = 1;
`endif
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAPTURE, S_DRAIN} state_t;

  state_t                             state_q, state_nxt;
  logic [CNT_W-1:0]                   cnt_q, cnt_nxt;
  logic [PASS_W-1:0]                  pass_q, pass_nxt;
  logic [NUM_LANES-1:0][PE_WIDTH-1:0] lanes_q, lanes_nxt;
  logic [LANE_W-1:0]                  lane_q, lane_nxt;
  logic [PE_WIDTH-1:0]                data_q, data_nxt;
  logic                               valid_q, valid_nxt;
  logic                               last_q, last_nxt;
  logic                               overrun_q, overrun_nxt;
  logic                               handshake;

  assign busy      = (state_q != S_IDLE);
  assign handshake = valid_q & out_ready;

  always_comb begin
    state_nxt   = state_q;
    cnt_nxt     = cnt_q;
    pass_nxt    = pass_q;
    lanes_nxt   = lanes_q;
    lane_nxt    = lane_q;
    data_nxt    = data_q;
    valid_nxt   = valid_q;
    last_nxt    = last_q;
    overrun_nxt = overrun_q | (start & busy);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_nxt   = CNT_W'(LATENCY - 1);
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // Capture happens on the edge that leaves WAIT so the sample lands LATENCY edges after start.
        if (cnt_q == '0) begin
          state_nxt = S_CAPTURE;
          lane_nxt  = '0;
          pass_nxt  = pass_q + PASS_W'(1);
`ifdef PSUM_DRAIN_ACC_EN
          for (int i = 0; i < NUM_LANES; i++)
            lanes_nxt[i] = lanes_q[i] + psum_in_flat[PE_WIDTH*i +: PE_WIDTH];
`else
          lanes_nxt = psum_in_flat;
`endif
        end else begin
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        if (int'(pass_q) < PASS_TARGET) begin
          state_nxt = S_IDLE;
        end else begin
          state_nxt = S_DRAIN;
          valid_nxt = 1'b1;
          data_nxt  = lanes_q[0];
          last_nxt  = (LAST_LANE == '0);
        end
      end
      S_DRAIN: begin
        if (handshake) begin
          if (lane_q == LAST_LANE) begin
            state_nxt = S_IDLE;
            valid_nxt = 1'b0;
            data_nxt  = '0;
            last_nxt  = 1'b0;
            lane_nxt  = '0;
            pass_nxt  = '0;
            lanes_nxt = '0;
          end else begin
            lane_nxt = lane_q + LANE_W'(1);
            data_nxt = lanes_q[lane_nxt];
            last_nxt = (lane_nxt == LAST_LANE);
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      pass_q    <= '0;
      lanes_q   <= '0;
      lane_q    <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_nxt;
      cnt_q     <= cnt_nxt;
      pass_q    <= pass_nxt;
      lanes_q   <= lanes_nxt;
      lane_q    <= lane_nxt;
      data_q    <= data_nxt;
      valid_q   <= valid_nxt;
      last_q    <= last_nxt;
      overrun_q <= overrun_nxt;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_lane  = lane_q;
  assign out_last  = last_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_psum_drain.sv
// Self-checking bench for psum_drain: vector table, hand-written corner sequences and
// randomized passes checked against a pass-level reference model.
module tb_psum_drain;
  localparam int PW  = 4;
  localparam int NL  = 3;
  localparam int LAT = 30;
  localparam int PS  = 3;
`ifdef PSUM_DRAIN_ACC_EN
  localparam int P_EFF = PS;
`else
  localparam int P_EFF = 1;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [PW*NL-1:0] psum_in_flat;
  logic            out_valid;
  logic            out_ready;
  logic [PW-1:0]   out_data;
  logic [1:0]      out_lane;
  logic            out_last;
  logic            busy;
  logic            overrun;

  always #5 clk = ~clk;

  psum_drain #(.PE_WIDTH(PW), .NUM_LANES(NL), .LATENCY(LAT), .PASSES(PS)) dut (
    .clk(clk), .rst(rst), .start(start), .psum_in_flat(psum_in_flat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane(out_lane), .out_last(out_last), .busy(busy), .overrun(overrun)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Reference model: per-lane running sums, drained and cleared every P_EFF-th pass.
  logic [PW-1:0] m_acc [NL];
  logic [PW-1:0] m_exp [NL];
  int            m_pcnt;
  bit            m_drain;

  task automatic model_reset;
    for (int i = 0; i < NL; i++) m_acc[i] = '0;
    m_pcnt = 0;
  endtask

  task automatic model_pass(input logic [PW*NL-1:0] p);
    m_pcnt++;
    for (int i = 0; i < NL; i++) m_acc[i] = m_acc[i] + p[PW*i +: PW];
    m_drain = (m_pcnt == P_EFF);
    if (m_drain) begin
      for (int i = 0; i < NL; i++) begin
        m_exp[i] = m_acc[i];
        m_acc[i] = '0;
      end
      m_pcnt = 0;
    end
  endtask

  task automatic run_pass(input logic [PW*NL-1:0] p, input int stall, input bit rnd,
                          input int ovr_at, input bit start_at_last,
                          input bit use_tbl, input logic [PW*NL-1:0] tbl_exp);
    logic [PW-1:0] exp_l [NL];
    logic [PW-1:0] bd [$];
    logic [1:0]    bl [$];
    logic          bls [$];
    bit            done, stalled;
    logic [PW-1:0] pd;
    logic [1:0]    pl;
    int            stall_left;
    model_pass(p);
    for (int i = 0; i < NL; i++) exp_l[i] = use_tbl ? tbl_exp[PW*i +: PW] : m_exp[i];
    psum_in_flat = p;
    start = 1'b1;
    tick;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int i = 1; i <= LAT; i++) begin
      tick;
      start = (ovr_at > 0 && i == ovr_at);
    end
    check("valid_before_capture", out_valid, 0);
    psum_in_flat = PW*NL'($urandom);
    tick;
    if (!m_drain) begin
      check("no_valid_midpass", out_valid, 0);
      check("idle_midpass", busy, 0);
      return;
    end
    check("valid_rise", out_valid, 1);
    done = 0;
    stalled = 0;
    pd = '0;
    pl = '0;
    stall_left = stall;
    for (int c = 0; c < 200 && !done; c++) begin
      if (stalled) begin
        check("stall_valid", out_valid, 1);
        check("stall_data", out_data, pd);
        check("stall_lane", out_lane, pl);
      end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (out_valid && out_ready) begin
        bd.push_back(out_data);
        bl.push_back(out_lane);
        bls.push_back(out_last);
        if (out_last) begin
          done = 1;
          if (start_at_last) start = 1'b1;
        end
      end
      stalled = out_valid && !out_ready;
      pd = out_data;
      pl = out_lane;
      tick;
      start = 1'b0;
    end
    out_ready = 1'b1;
    if (!done) check("drain_timeout", 0, 1);
    check("beat_count", bd.size(), NL);
    for (int i = 0; i < NL && i < bd.size(); i++) begin
      check("beat_data", bd[i], exp_l[i]);
      check("beat_lane", bl[i], i);
      check("beat_last", bls[i], (i == NL - 1));
    end
    check("busy_fall", busy, 0);
    check("valid_fall", out_valid, 0);
  endtask

  task automatic prime;
    while (m_pcnt < P_EFF - 1) run_pass(PW*NL'($urandom), 0, 0, 0, 0, 0, '0);
  endtask

  typedef struct {
    logic [PW*NL-1:0] psum;
    int               stall;
    logic [PW*NL-1:0] exp;
  } vec_t;

  vec_t tbl [$];

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef PSUM_DRAIN_ACC_EN
    tbl.push_back('{12'h555, 0, 12'h000});
    tbl.push_back('{12'h555, 0, 12'h000});
    tbl.push_back('{12'h555, 5, 12'hFFF});
    tbl.push_back('{12'h999, 0, 12'h000});
    tbl.push_back('{12'h000, 0, 12'h000});
    tbl.push_back('{12'h000, 1, 12'h999});
    tbl.push_back('{12'h999, 0, 12'h000});
    tbl.push_back('{12'h999, 0, 12'h000});
    tbl.push_back('{12'h000, 2, 12'h222});
`else
    tbl.push_back('{12'h321, 0, 12'h321});
    tbl.push_back('{12'h321, 5, 12'h321});
    tbl.push_back('{12'hA5F, 2, 12'hA5F});
    tbl.push_back('{12'h000, 0, 12'h000});
    tbl.push_back('{12'hFFF, 1, 12'hFFF});
`endif
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    psum_in_flat = '0;
    model_reset;
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_lane", out_lane, 0);
    check("rst_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    tick;

    foreach (tbl[i]) run_pass(tbl[i].psum, tbl[i].stall, 0, 0, 0, 1, tbl[i].exp);
    check("no_overrun_b2b", overrun, 0);

    repeat (10) run_pass(PW*NL'($urandom), $urandom_range(0, 2), 1, 0, 0, 0, '0);
    check("no_overrun_random", overrun, 0);

    // Reset while lane 1 is on the bus, then a fresh pass.
    prime;
    psum_in_flat = 12'h654;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (LAT + 1) tick;
    check("pre_rst_valid", out_valid, 1);
    tick;
    check("pre_rst_lane", out_lane, 1);
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", out_data, 0);
    check("async_rst_lane", out_lane, 0);
    check("async_rst_last", out_last, 0);
    check("async_rst_busy", busy, 0);
    model_reset;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    tick;
    check("post_rst_idle", out_valid, 0);
    prime;
    run_pass(12'h7A3, 1, 0, 0, 0, 0, '0);

    // Second start while waiting: ignored, flagged, no second drain.
    prime;
    run_pass(12'h321, 0, 0, 15, 0, 0, '0);
    check("overrun_set", overrun, 1);
    for (int i = 0; i < LAT + 5; i++) begin
      tick;
      if (out_valid || busy) check("ghost_pass", {out_valid, busy}, 0);
    end
    check("ghost_pass_end", {out_valid, busy}, 0);
    check("overrun_sticky", overrun, 1);

    rst = 1'b1;
    model_reset;
    @(negedge clk);
    rst = 1'b0;
    tick;
    check("overrun_cleared", overrun, 0);

    // Start coinciding with the final handshake counts as overrun and is dropped.
    prime;
    run_pass(PW*NL'($urandom), 0, 0, 0, 1, 0, '0);
    check("overrun_last_beat", overrun, 1);
    tick;
    check("last_beat_start_ignored", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
